case_3_prod_accum: RTL and testbench

Frame accumulator that sits directly downstream of the case_3 7-bit signed multiplier. It accepts one signed product per handshake, sums FRAME_LEN consecutive products with signed saturation, then presents the frame sum and a per-frame saturation flag on a valid/ready output port. The kernel datapath uses it to reduce multiplier output streams to one result per frame.

---
 rtl/case_3_prod_accum.sv | 94 +++++++++
 tb/tb_case_3_prod_accum.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/case_3_prod_accum.sv
// ============================================================================
// Module   : case_3_prod_accum
// Purpose  : Saturating frame accumulator for signed multiplier products,
//            one result per FRAME_LEN products on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module case_3_prod_accum #(
  parameter int PROD_WIDTH = 7,
  parameter int ACC_WIDTH  = 9,
  parameter int FRAME_LEN  = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [PROD_WIDTH-1:0] prod_din,
  input  logic                  prod_vld,
  output logic                  prod_rdy,
  output logic [ACC_WIDTH-1:0]  acc_dout,
  output logic                  acc_ovf,
  output logic                  acc_vld,
  input  logic                  acc_rdy
);

  localparam int                   c_cnt_w = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [c_cnt_w-1:0]   c_last  = c_cnt_w'(FRAME_LEN - 1);
  localparam logic [ACC_WIDTH-1:0] c_max   = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] c_min   = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [0:0] {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_ovf;

  logic [ACC_WIDTH:0]   w_ext;
  logic [ACC_WIDTH:0]   w_sum;
  logic                 w_pos_ovf;
  logic                 w_neg_ovf;
  logic [ACC_WIDTH-1:0] w_sat;
  logic                 w_accept;

  // One guard bit: the two top bits disagree exactly when the sum left range.
  assign w_ext     = {{(ACC_WIDTH+1-PROD_WIDTH){prod_din[PROD_WIDTH-1]}}, prod_din};
  assign w_sum     = w_ext + {r_acc[ACC_WIDTH-1], r_acc};
  assign w_pos_ovf = ~w_sum[ACC_WIDTH] &  w_sum[ACC_WIDTH-1];
  assign w_neg_ovf =  w_sum[ACC_WIDTH] & ~w_sum[ACC_WIDTH-1];
  assign w_sat     = w_pos_ovf ? c_max : (w_neg_ovf ? c_min : w_sum[ACC_WIDTH-1:0]);
  assign w_accept  = (r_state == ST_ACC) && prod_vld;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= ST_ACC;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_ACC: begin
          if (w_accept) begin
            r_acc <= w_sat;
            r_ovf <= r_ovf | w_pos_ovf | w_neg_ovf;
            if (r_cnt == c_last) begin
              r_cnt   <= '0;
              r_state <= ST_OUT;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_OUT: begin
          if (acc_rdy) begin
            r_state <= ST_ACC;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
          end
        end
        default: r_state <= ST_ACC;
      endcase
    end
  end

  assign prod_rdy = (r_state == ST_ACC);
  assign acc_vld  = (r_state == ST_OUT);
  assign acc_dout = r_acc;
  assign acc_ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_case_3_prod_accum.sv
// ============================================================================
// Module   : tb_case_3_prod_accum
// Purpose  : Scoreboard bench for case_3_prod_accum with a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_case_3_prod_accum;

  localparam int PW = 7;
  localparam int AW = 9;
  localparam int FL = 8;
  localparam int MAXV = (1 << (AW-1)) - 1;
  localparam int MINV = -(1 << (AW-1));

  logic          ap_clk = 1'b0;
  logic          ap_rst = 1'b1;
  logic [PW-1:0] prod_din = '0;
  logic          prod_vld = 1'b0;
  logic          prod_rdy;
  logic [AW-1:0] acc_dout;
  logic          acc_ovf;
  logic          acc_vld;
  logic          acc_rdy = 1'b0;

  int errors = 0;
  int checks = 0;

  typedef struct { int sum; bit ovf; } res_t;
  res_t exp_q[$];

  // Frame-level reference: running sum, sticky flag, beat count, result pending.
  int m_acc = 0;
  bit m_ovf = 0;
  int m_cnt = 0;
  bit m_pending = 0;

  case_3_prod_accum #(.PROD_WIDTH(PW), .ACC_WIDTH(AW), .FRAME_LEN(FL)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .prod_din(prod_din), .prod_vld(prod_vld), .prod_rdy(prod_rdy),
    .acc_dout(acc_dout), .acc_ovf(acc_ovf), .acc_vld(acc_vld), .acc_rdy(acc_rdy)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_accept(input int v);
    int s;
    s = m_acc + v;
    if (s > MAXV) begin s = MAXV; m_ovf = 1; end
    else if (s < MINV) begin s = MINV; m_ovf = 1; end
    m_acc = s;
    m_cnt++;
    if (m_cnt == FL) begin
      exp_q.push_back('{sum: m_acc, ovf: m_ovf});
      m_acc = 0; m_ovf = 0; m_cnt = 0; m_pending = 1;
    end
  endfunction

  // Monitor: compares the presented result with the scoreboard head.
  always @(negedge ap_clk) begin
    if (!ap_rst && acc_vld) begin
      if (exp_q.size() == 0) begin
        check_int("unexpected_result", 1, 0);
      end else begin
        check_int("acc_dout", int'($signed(acc_dout)), exp_q[0].sum);
        check_int("acc_ovf", int'(acc_ovf), int'(exp_q[0].ovf));
        if (acc_rdy) void'(exp_q.pop_front());
      end
    end
  end

  // Called at posedge+1; drives one cycle and checks the handshake outputs.
  task automatic drive_cycle(input bit vld, input int din, input bit ardy, output bit accepted);
    bit hs;
    prod_vld = vld;
    prod_din = din[PW-1:0];
    acc_rdy  = ardy;
    check_int("prod_rdy", int'(prod_rdy), int'(!m_pending));
    check_int("acc_vld", int'(acc_vld), int'(m_pending));
    accepted = vld && !m_pending;
    hs = m_pending && ardy;
    @(posedge ap_clk);
    if (hs) m_pending = 0;
    if (accepted) model_accept(din);
    #1;
  endtask

  task automatic do_reset();
    ap_rst = 1'b1;
    prod_vld = 1'b0;
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    m_acc = 0; m_ovf = 0; m_cnt = 0; m_pending = 0;
    exp_q.delete();
    check_int("rst_prod_rdy", int'(prod_rdy), 1);
    check_int("rst_acc_vld", int'(acc_vld), 0);
    check_int("rst_acc_dout", int'($signed(acc_dout)), 0);
    check_int("rst_acc_ovf", int'(acc_ovf), 0);
  endtask

  task automatic send(input int vals[$], input int gap_pct, input int ardy_pct);
    int idx = 0;
    int cyc = 0;
    bit acc;
    while (idx < vals.size()) begin
      drive_cycle($urandom_range(99, 0) >= gap_pct, vals[idx],
                  $urandom_range(99, 0) < ardy_pct, acc);
      if (acc) idx++;
      if (++cyc > 2000) begin
        check_int("send_timeout", cyc, 0);
        return;
      end
    end
  endtask

  task automatic idle(input int n, input bit ardy);
    bit acc;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 0, ardy, acc);
  endtask

  function automatic void fill(ref int q[$], input int v, input int n);
    for (int i = 0; i < n; i++) q.push_back(v);
  endfunction

  initial begin
    int q[$];
    bit acc;
    repeat (2) @(posedge ap_clk);
    #1;
    do_reset();

    // Basic sum 1..8 back-to-back
    q = '{1, 2, 3, 4, 5, 6, 7, 8};
    send(q, 0, 100);
    idle(2, 1'b1);

    // Positive clamp then negative clamp in the next frame
    q.delete(); fill(q, 63, 8);  send(q, 0, 100);
    q.delete(); fill(q, -64, 8); send(q, 0, 100);
    idle(2, 1'b1);

    // Clamp then recover from the clamped value
    q.delete(); fill(q, 63, 5); fill(q, -64, 3);
    send(q, 0, 100);
    idle(2, 1'b1);

    // Backpressure: result held, stalled input ignored
    q.delete(); fill(q, -3, 8);
    send(q, 0, 0);
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 10, 1'b0, acc);
    idle(1, 1'b1);
    q = '{1, 2, 3, 4, 5, 6, 7, 8};
    send(q, 0, 100);
    idle(2, 1'b1);

    // Input gaps
    q.delete(); fill(q, -1, 8);
    send(q, 50, 100);
    idle(2, 1'b1);

    // Reset after 5 of 8 beats
    q.delete(); fill(q, 5, 5);
    send(q, 0, 100);
    do_reset();
    q.delete(); fill(q, 2, 8);
    send(q, 0, 100);
    idle(2, 1'b1);

    // Reset while a result is pending
    q.delete(); fill(q, 9, 8);
    send(q, 0, 0);
    idle(2, 1'b0);
    do_reset();
    idle(2, 1'b1);

    // Randomized frames with random gaps and backpressure
    for (int f = 0; f < 30; f++) begin
      q.delete();
      for (int i = 0; i < FL; i++) q.push_back(int'($urandom_range(127, 0)) - 64);
      send(q, 30, 60);
    end

    idle(20, 1'b1);
    check_int("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
